// File: rtl/down_counter_load.sv
// Binary down counter with synchronous parallel load, cascade borrow and a
// registered expiry pulse; terminal-count policy chosen by Mode.
module down_counter_load #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             Clear,
  input  logic [WIDTH-1:0] Data_in,
  input  logic             Load,
  input  logic             Count,
  input  logic [1:0]       Mode,
  output logic [WIDTH-1:0] A_count,
  output logic             B_out,
  output logic             Done,
  output logic             Armed
);

  typedef enum logic {
    ARMED   = 1'b0,
    EXPIRED = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] reload_next;
  logic [WIDTH-1:0] count_next;
  logic             done_next;
  logic             tc;
  logic             step;

  always_ff @(posedge CLK) begin
    if (Clear) begin
      state      <= ARMED;
      A_count    <= '0;
      reload_reg <= '0;
      Done       <= 1'b0;
    end else begin
      state      <= state_next;
      A_count    <= count_next;
      reload_reg <= reload_next;
      Done       <= done_next;
    end
  end

  always_comb begin
    tc          = (A_count == '0);
    step        = Count & ~Load & (state == ARMED);
    state_next  = state;
    count_next  = A_count;
    reload_next = reload_reg;
    // step already excludes Load, so a Load edge clears Done as well
    done_next   = step & tc;
    if (Load) begin
      count_next  = Data_in;
      reload_next = Data_in;
      state_next  = ARMED;
    end else if (step) begin
      if (!tc) begin
        count_next = A_count - WIDTH'(1);
      end else begin
        case (Mode)
          2'b01:   state_next = EXPIRED;
          2'b10:   count_next = reload_reg;
          default: count_next = '1;
        endcase
      end
    end
  end

  // Borrow is combinational so a cascaded stage steps on the same edge
  assign B_out = step & tc;
  assign Armed = (state == ARMED);

endmodule

// File: tb/tb_down_counter_load.sv
// Bench for down_counter_load: directed vector table on a single 4-bit stage,
// plus a two-stage cascade checked against an 8-bit down-counter model.
module tb_down_counter_load;

  logic       CLK;
  logic       Clear;
  logic [3:0] Data_in;
  logic       Load;
  logic       Count;
  logic [1:0] Mode;
  logic [3:0] A_count;
  logic       B_out;
  logic       Done;
  logic       Armed;

  // Cascade signals
  logic       c_clear;
  logic       c_load;
  logic       c_en;
  logic [1:0] c_mode;
  logic [7:0] c_din;
  logic [3:0] lo_q, hi_q;
  logic       lo_bout, hi_bout, lo_done, hi_done, lo_armed, hi_armed;

  int n_cmp = 0;
  int n_err = 0;

  down_counter_load #(.WIDTH(4)) dut (
    .CLK(CLK), .Clear(Clear), .Data_in(Data_in), .Load(Load), .Count(Count),
    .Mode(Mode), .A_count(A_count), .B_out(B_out), .Done(Done), .Armed(Armed)
  );

  down_counter_load #(.WIDTH(4)) stage_lo (
    .CLK(CLK), .Clear(c_clear), .Data_in(c_din[3:0]), .Load(c_load), .Count(c_en),
    .Mode(c_mode), .A_count(lo_q), .B_out(lo_bout), .Done(lo_done), .Armed(lo_armed)
  );

  down_counter_load #(.WIDTH(4)) stage_hi (
    .CLK(CLK), .Clear(c_clear), .Data_in(c_din[7:4]), .Load(c_load), .Count(lo_bout),
    .Mode(c_mode), .A_count(hi_q), .B_out(hi_bout), .Done(hi_done), .Armed(hi_armed)
  );

  // Clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       clr;
    logic       ld;
    logic       cnt;
    logic [1:0] mode;
    logic [3:0] din;
    logic       bout;   // before the edge
    logic [3:0] q;      // after the edge
    logic       done;
    logic       armed;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic clr, input logic ld, input logic cnt,
                     input logic [1:0] mode, input logic [3:0] din,
                     input logic bout, input logic [3:0] q,
                     input logic done, input logic armed);
    vec_t v;
    v.clr = clr; v.ld = ld; v.cnt = cnt; v.mode = mode; v.din = din;
    v.bout = bout; v.q = q; v.done = done; v.armed = armed;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  // Driver: inputs are applied 1 time unit after a rising edge
  task automatic apply(input int idx);
    vec_t v;
    v = vecs[idx];
    Clear = v.clr; Load = v.ld; Count = v.cnt; Mode = v.mode; Data_in = v.din;
    #2;
    check("B_out", idx, {31'd0, B_out}, {31'd0, v.bout});
    @(posedge CLK);
    #1;
    check("A_count", idx, {28'd0, A_count}, {28'd0, v.q});
    check("Done", idx, {31'd0, Done}, {31'd0, v.done});
    check("Armed", idx, {31'd0, Armed}, {31'd0, v.armed});
  endtask

  logic [7:0] model_v;
  logic       exp_hi_bout, exp_lo_done, exp_hi_done;

  initial begin
    Clear = 1'b0; Load = 1'b0; Count = 1'b0; Mode = 2'b00; Data_in = 4'd0;
    c_clear = 1'b1; c_load = 1'b0; c_en = 1'b0; c_mode = 2'b00; c_din = 8'h00;

    //   clr ld cnt mode   din   bout q      done armed
    // One-shot countdown from 3
    add(1, 0, 0, 2'b01, 4'd0, 0, 4'd0,  0, 1);
    add(0, 1, 0, 2'b01, 4'd3, 0, 4'd3,  0, 1);
    add(0, 0, 1, 2'b01, 4'd0, 0, 4'd2,  0, 1);
    add(0, 0, 1, 2'b01, 4'd0, 0, 4'd1,  0, 1);
    add(0, 0, 1, 2'b01, 4'd0, 0, 4'd0,  0, 1);
    add(0, 0, 1, 2'b01, 4'd0, 1, 4'd0,  1, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 1, 2'b01, 4'd0, 0, 4'd0, 0, 0);
    add(0, 1, 0, 2'b01, 4'd7, 0, 4'd7,  0, 1);
    // Free-run wrap from 0
    add(0, 1, 0, 2'b00, 4'd0, 0, 4'd0,  0, 1);
    add(0, 0, 1, 2'b00, 4'd0, 1, 4'd15, 1, 1);
    add(0, 0, 1, 2'b00, 4'd0, 0, 4'd14, 0, 1);
    add(0, 0, 1, 2'b00, 4'd0, 0, 4'd13, 0, 1);
    // Auto-reload from 2: next values 1,0,2 repeated three times
    add(0, 1, 0, 2'b10, 4'd2, 0, 4'd2,  0, 1);
    for (int r = 0; r < 3; r++) begin
      add(0, 0, 1, 2'b10, 4'd0, 0, 4'd1, 0, 1);
      add(0, 0, 1, 2'b10, 4'd0, 0, 4'd0, 0, 1);
      add(0, 0, 1, 2'b10, 4'd0, 1, 4'd2, 1, 1);
    end
    // Auto-reload of 0 expires on every step
    add(0, 1, 0, 2'b10, 4'd0, 0, 4'd0,  0, 1);
    add(0, 0, 1, 2'b10, 4'd0, 1, 4'd0,  1, 1);
    add(0, 0, 1, 2'b10, 4'd0, 1, 4'd0,  1, 1);
    // Load beats Count at terminal count; Clear beats Load
    add(0, 1, 1, 2'b00, 4'd9, 0, 4'd9,  0, 1);
    add(0, 1, 0, 2'b00, 4'd5, 0, 4'd5,  0, 1);
    add(1, 1, 0, 2'b00, 4'd12, 0, 4'd0, 0, 1);
    // Count low holds
    add(0, 1, 0, 2'b00, 4'd6, 0, 4'd6,  0, 1);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 2'b00, 4'd0, 0, 4'd6, 0, 1);
    // Mode change while EXPIRED does not rearm
    add(0, 1, 0, 2'b01, 4'd1, 0, 4'd1,  0, 1);
    add(0, 0, 1, 2'b01, 4'd0, 0, 4'd0,  0, 1);
    add(0, 0, 1, 2'b01, 4'd0, 1, 4'd0,  1, 0);
    add(0, 0, 0, 2'b00, 4'd0, 0, 4'd0,  0, 0);
    add(0, 0, 1, 2'b00, 4'd0, 0, 4'd0,  0, 0);
    // Reserved mode wraps like free-run
    add(0, 1, 0, 2'b11, 4'd0, 0, 4'd0,  0, 1);
    add(0, 0, 1, 2'b11, 4'd0, 1, 4'd15, 1, 1);

    @(posedge CLK);
    #1;
    for (int i = 0; i < vecs.size(); i++) apply(i);
    Load = 1'b0; Count = 1'b0; Clear = 1'b0;

    // Two-stage cascade in free-run mode: 8'h01 then on through 8'h00 -> 8'hFF
    @(posedge CLK); #1;
    c_clear = 1'b0; c_load = 1'b1; c_din = 8'h01;
    @(posedge CLK); #1;
    c_load = 1'b0;
    check("casc_load", 0, {24'd0, hi_q, lo_q}, 32'h01);
    model_v = 8'h01;
    c_en = 1'b1;
    for (int s = 0; s < 40; s++) begin
      if (s == 20) begin
        // reload mid-run so the nibble boundary 8'h20 -> 8'h1F is crossed
        c_en = 1'b0; c_load = 1'b1; c_din = 8'h21;
        @(posedge CLK); #1;
        c_load = 1'b0; c_en = 1'b1;
        model_v = 8'h21;
      end
      #1;
      exp_hi_bout = (model_v == 8'h00);
      exp_lo_done = (model_v[3:0] == 4'h0);
      exp_hi_done = (model_v == 8'h00);
      check("casc_borrow", s, {31'd0, hi_bout}, {31'd0, exp_hi_bout});
      @(posedge CLK); #1;
      model_v = model_v - 8'd1;
      check("casc_value", s, {24'd0, hi_q, lo_q}, {24'd0, model_v});
      check("casc_lo_done", s, {31'd0, lo_done}, {31'd0, exp_lo_done});
      check("casc_hi_done", s, {31'd0, hi_done}, {31'd0, exp_hi_done});
    end
    c_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
